knn_sort_ctrl: RTL and testbench

- Sequencer sitting on both sides of the K=5 bitonic sorter.
- Front side: accepts 4-distance batches from the distance-calculator array (valid/ready), drives the sorter's clear, sorting-indication and distance inputs.
- Back side: reads the sorter's 5 nearest-neighbour group bits after the pipeline drains, majority-votes them into a class decision and reports it to the host with a done pulse.

---
 rtl/knn_sort_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_knn_sort_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/knn_sort_ctrl.sv
// knn_sort_ctrl: sequencer around the K=5 bitonic sorter.
// Front side: takes 4-distance batches from the distance calculators and
// feeds the sorter (clear, sorting indication, registered distances).
// Back side: after the sorter pipeline drains, majority-votes the K
// nearest-neighbour group bits and reports the class with a done pulse.
//
// Optional feature (macro KNN_SORT_CTRL_TIMEOUT_EN): an idle-beat watchdog
// in SORT that aborts the query after TIMEOUT_CYCLES cycles without an
// accepted beat and reports it on o_timeout.
//
// Handshake: a batch transfers on every rising clk edge where
// i_dist_valid && o_dist_ready. o_dist_ready depends only on controller
// state and the accepted-beat count, never on i_dist_valid, and the source
// must hold i_distance stable while i_dist_valid is high and not yet taken.
module knn_sort_ctrl #(
  parameter int DIST_W         = 12,
  parameter int NUM_DIST       = 4,
  parameter int K              = 5,
  parameter int BATCH_CNT_W    = 10,
  parameter int SORT_LATENCY   = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_start,
  input  logic [BATCH_CNT_W-1:0]       i_num_batches,
  input  logic                         i_dist_valid,
  input  logic [DIST_W*NUM_DIST-1:0]   i_distance,
  output logic                         o_dist_ready,
  output logic                         o_sorting_indication,
  output logic [DIST_W*NUM_DIST-1:0]   o_distance,
  output logic                         o_clr_smallest_data_regs,
  input  logic [K-1:0]                 i_5_smallest_distances_group_bit,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_class,
  output logic [2:0]                   o_vote_count,
  output logic                         o_empty,
`ifdef KNN_SORT_CTRL_TIMEOUT_EN
  output logic                         o_timeout,
`endif
  output logic [2:0]                   o_dbg_state
);

  localparam int DRAIN_W = (SORT_LATENCY < 2) ? 1 : $clog2(SORT_LATENCY + 1);
  localparam int VOTE_W  = $clog2(K + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SORT  = 3'd2,
    DRAIN = 3'd3,
    VOTE  = 3'd4
  } state_t;

  state_t                 state;
  logic [BATCH_CNT_W-1:0] num_batches_q;
  logic [BATCH_CNT_W-1:0] batch_cnt;
  logic [DRAIN_W-1:0]     drain_cnt;
  logic [VOTE_W-1:0]      vote_sum;
  logic                   accept;
  logic                   last_beat;

`ifdef KNN_SORT_CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] idle_cnt;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

  assign o_dbg_state = state;

  // Ready only in SORT while fewer beats than requested have been taken;
  // the count update at the last accepted beat drops ready right after it.
  assign o_dist_ready = (state == SORT) && (batch_cnt < num_batches_q);
  assign accept       = i_dist_valid && o_dist_ready;
  assign last_beat    = accept && ((batch_cnt + BATCH_CNT_W'(1)) == num_batches_q);

  // Population count of the sorter's group bits for the majority vote.
  always_comb begin
    vote_sum = '0;
    for (int i = 0; i < K; i++) begin
      vote_sum = vote_sum + VOTE_W'(i_5_smallest_distances_group_bit[i]);
    end
  end

  // Main sequencer: state, counters and every registered output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                    <= IDLE;
      num_batches_q            <= '0;
      batch_cnt                <= '0;
      drain_cnt                <= '0;
      o_sorting_indication     <= 1'b0;
      o_distance               <= '0;
      o_clr_smallest_data_regs <= 1'b0;
      o_busy                   <= 1'b0;
      o_done                   <= 1'b0;
      o_class                  <= 1'b0;
      o_vote_count             <= '0;
      o_empty                  <= 1'b0;
`ifdef KNN_SORT_CTRL_TIMEOUT_EN
      idle_cnt                 <= '0;
      o_timeout                <= 1'b0;
`endif
    end else begin
      // Pulses default low; the distance register only moves on a beat.
      o_done                   <= 1'b0;
      o_clr_smallest_data_regs <= 1'b0;
      o_sorting_indication     <= accept;
      if (accept) begin
        o_distance <= i_distance;
      end
`ifdef KNN_SORT_CTRL_TIMEOUT_EN
      o_timeout <= 1'b0;
`endif

      case (state)
        IDLE: begin
          if (i_start) begin
            o_class      <= 1'b0;
            o_vote_count <= '0;
            batch_cnt    <= '0;
            if (i_num_batches != '0) begin
              num_batches_q            <= i_num_batches;
              o_busy                   <= 1'b1;
              o_empty                  <= 1'b0;
              o_clr_smallest_data_regs <= 1'b1;
              state                    <= CLEAR;
            end else begin
              // Empty query: nothing to sort, report immediately.
              o_done  <= 1'b1;
              o_empty <= 1'b1;
            end
          end
        end

        CLEAR: begin
          // The clear pulse is visible during this single cycle.
`ifdef KNN_SORT_CTRL_TIMEOUT_EN
          idle_cnt <= '0;
`endif
          state <= SORT;
        end

        SORT: begin
          if (accept) begin
            batch_cnt <= batch_cnt + BATCH_CNT_W'(1);
`ifdef KNN_SORT_CTRL_TIMEOUT_EN
            idle_cnt  <= '0;
`endif
            if (last_beat) begin
              drain_cnt <= '0;
              state     <= DRAIN;
            end
          end
`ifdef KNN_SORT_CTRL_TIMEOUT_EN
          else if (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            // Source stalled too long: abort, clear the sorter, report.
            o_clr_smallest_data_regs <= 1'b1;
            o_done                   <= 1'b1;
            o_timeout                <= 1'b1;
            o_class                  <= 1'b0;
            o_vote_count             <= '0;
            o_empty                  <= 1'b0;
            o_busy                   <= 1'b0;
            idle_cnt                 <= '0;
            state                    <= IDLE;
          end else begin
            idle_cnt <= idle_cnt + TO_W'(1);
          end
`endif
        end

        DRAIN: begin
          // First DRAIN cycle carries the final indication; the remaining
          // cycles let the sorter pipeline settle before the vote.
          if (drain_cnt == DRAIN_W'(SORT_LATENCY - 1)) begin
            drain_cnt <= '0;
            state     <= VOTE;
          end else begin
            drain_cnt <= drain_cnt + DRAIN_W'(1);
          end
        end

        VOTE: begin
          o_vote_count <= 3'(vote_sum);
          o_class      <= (vote_sum >= VOTE_W'((K + 1) / 2));
          o_done       <= 1'b1;
          o_busy       <= 1'b0;
          state        <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_knn_sort_ctrl.sv
// Directed testbench for knn_sort_ctrl: reset/idle, full-rate and gapped
// queries, empty query, ignored start and ignored valid while draining,
// and asynchronous reset in the middle of a query.
module tb_knn_sort_ctrl;

  localparam int DIST_W   = 12;
  localparam int NUM_DIST = 4;
  localparam int K        = 5;
  localparam int BCW      = 10;
  localparam int DW       = DIST_W * NUM_DIST;

  // ---------------- clock / reset ----------------
  logic          clk;
  logic          rst;
  logic          i_start;
  logic [BCW-1:0] i_num_batches;
  logic          i_dist_valid;
  logic [DW-1:0] i_distance;
  logic          o_dist_ready;
  logic          o_sorting_indication;
  logic [DW-1:0] o_distance;
  logic          o_clr_smallest_data_regs;
  logic [K-1:0]  group_bits;
  logic          o_busy;
  logic          o_done;
  logic          o_class;
  logic [2:0]    o_vote_count;
  logic          o_empty;
  logic [2:0]    o_dbg_state;
`ifdef KNN_SORT_CTRL_TIMEOUT_EN
  logic          o_timeout;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  knn_sort_ctrl dut (
    .clk                              (clk),
    .rst                              (rst),
    .i_start                          (i_start),
    .i_num_batches                    (i_num_batches),
    .i_dist_valid                     (i_dist_valid),
    .i_distance                       (i_distance),
    .o_dist_ready                     (o_dist_ready),
    .o_sorting_indication             (o_sorting_indication),
    .o_distance                       (o_distance),
    .o_clr_smallest_data_regs         (o_clr_smallest_data_regs),
    .i_5_smallest_distances_group_bit (group_bits),
    .o_busy                           (o_busy),
    .o_done                           (o_done),
    .o_class                          (o_class),
    .o_vote_count                     (o_vote_count),
    .o_empty                          (o_empty),
`ifdef KNN_SORT_CTRL_TIMEOUT_EN
    .o_timeout                        (o_timeout),
`endif
    .o_dbg_state                      (o_dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int n_checks;
  int n_fail;
  int cyc;
  int ind_cnt;
  int clr_cnt;
  int done_cnt;
  int first_ind_cyc;
  int last_ind_cyc;
  int clr_cyc;
  int done_cyc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Record what the DUT shows in the current cycle.
  task automatic observe();
    logic [DW-1:0] e;
    if (o_sorting_indication) begin
      if (ind_cnt == 0) first_ind_cyc = cyc;
      last_ind_cyc = cyc;
      ind_cnt++;
      if (exp_q.size() == 0) begin
        check("ind_extra", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("ind_dist", o_distance, e);
      end
    end
    if (o_clr_smallest_data_regs) begin
      clr_cnt++;
      clr_cyc = cyc;
    end
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    cyc++;
  endtask

  task automatic clear_obs();
    exp_q.delete();
    ind_cnt = 0; clr_cnt = 0; done_cnt = 0;
    first_ind_cyc = -1; last_ind_cyc = -1; clr_cyc = -1; done_cyc = -1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    observe();
  endtask

  task automatic start_query(input int num);
    i_start       = 1'b1;
    i_num_batches = BCW'(num);
    step();
    i_start       = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d);
    int n;
    n = 0;
    i_dist_valid = 1'b1;
    i_distance   = d;
    while (!o_dist_ready && n < 20) begin
      step();
      n++;
    end
    if (!o_dist_ready) begin
      check("ready_timeout", 0, 1);
    end else begin
      exp_q.push_back(d);
    end
    step();
    i_dist_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (done_cnt == 0 && n < bound) begin
      step();
      n++;
    end
    check("done_seen", done_cnt, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, o_dist_ready, 0);
    check({tag, "_ind"},   o_sorting_indication, 0);
    check({tag, "_dist"},  o_distance, 0);
    check({tag, "_clr"},   o_clr_smallest_data_regs, 0);
    check({tag, "_busy"},  o_busy, 0);
    check({tag, "_done"},  o_done, 0);
    check({tag, "_class"}, o_class, 0);
    check({tag, "_votes"}, o_vote_count, 0);
    check({tag, "_empty"}, o_empty, 0);
    check({tag, "_state"}, o_dbg_state, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0; n_fail = 0; cyc = 0;
    clear_obs();
    rst = 1'b1; i_start = 1'b0; i_num_batches = '0;
    i_dist_valid = 1'b0; i_distance = '0; group_bits = '0;

    // Reset, then 10 idle cycles.
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("rst");
    rst = 1'b1;
    repeat (10) step();
    check_all_zero("idle");

    // Query of 3 back-to-back beats, bits 10110 -> 3 votes, class 1.
    clear_obs();
    group_bits = 5'b10110;
    start_query(3);
    check("q1_busy", o_busy, 1);
    send_beat(48'h001_002_003_004);
    send_beat(48'hABC_DEF_123_456);
    send_beat(48'hFFF_000_7FF_800);
    wait_done(30);
    check("q1_ind_cnt", ind_cnt, 3);
    check("q1_ind_consec", last_ind_cyc - first_ind_cyc, 2);
    check("q1_clr_cnt", clr_cnt, 1);
    check("q1_clr_before_ind", (clr_cyc >= 0) && (clr_cyc < first_ind_cyc), 1);
    check("q1_done_lat", done_cyc - last_ind_cyc, 3);
    check("q1_class", o_class, 1);
    check("q1_votes", o_vote_count, 3);
    check("q1_empty", o_empty, 0);
    check("q1_busy_end", o_busy, 0);
    check("q1_q_empty", exp_q.size(), 0);
    step();
    check("q1_done_pulse", o_done, 0);
    check("q1_class_hold", o_class, 1);
    check("q1_votes_hold", o_vote_count, 3);

    // Query of 2 beats with a one-cycle gap, bits 00001 -> 1 vote, class 0.
    clear_obs();
    group_bits = 5'b00001;
    start_query(2);
    check("q2_class_cleared", o_class, 0);
    check("q2_votes_cleared", o_vote_count, 0);
    send_beat(48'h111_222_333_444);
    step();
    send_beat(48'h555_666_777_888);
    wait_done(30);
    check("q2_ind_cnt", ind_cnt, 2);
    check("q2_ind_gap", last_ind_cyc - first_ind_cyc, 2);
    check("q2_done_lat", done_cyc - last_ind_cyc, 3);
    check("q2_class", o_class, 0);
    check("q2_votes", o_vote_count, 1);

    // Empty query: done next cycle with o_empty, no clear, no indication.
    clear_obs();
    start_query(0);
    check("q0_done", o_done, 1);
    check("q0_empty", o_empty, 1);
    check("q0_class", o_class, 0);
    check("q0_votes", o_vote_count, 0);
    check("q0_busy", o_busy, 0);
    step();
    step();
    check("q0_clr_cnt", clr_cnt, 0);
    check("q0_ind_cnt", ind_cnt, 0);
    check("q0_done_cnt", done_cnt, 1);
    check("q0_empty_hold", o_empty, 1);

    // Start during SORT ignored; valid held through DRAIN ignored.
    clear_obs();
    group_bits = 5'b11111;
    start_query(2);
    check("q3_empty_cleared", o_empty, 0);
    send_beat(48'h0A0_0B0_0C0_0D0);
    i_start = 1'b1;
    i_num_batches = BCW'(7);
    send_beat(48'h123_456_789_ABC);
    i_start = 1'b0;
    i_dist_valid = 1'b1;
    i_distance = 48'hDEA_DBE_EF0_000;
    for (int n = 0; n < 20 && done_cnt == 0; n++) begin
      check("q3_ready_drain", o_dist_ready, 0);
      step();
    end
    check("q3_done_seen", done_cnt, 1);
    check("q3_done_lat", done_cyc - last_ind_cyc, 3);
    check("q3_class", o_class, 1);
    check("q3_votes", o_vote_count, 5);
    i_dist_valid = 1'b0;
    repeat (3) step();
    check("q3_ind_cnt", ind_cnt, 2);
    check("q3_clr_cnt", clr_cnt, 1);
    check("q3_busy_end", o_busy, 0);

    // Asynchronous reset after 1 of 4 beats, then a 1-beat query.
    clear_obs();
    start_query(4);
    send_beat(48'h321_654_987_CBA);
    check("q4_busy_mid", o_busy, 1);
    #2 rst = 1'b0;
    #1;
    check_all_zero("arst");
    step();
    rst = 1'b1;
    clear_obs();
    group_bits = 5'b00011;
    start_query(1);
    send_beat(48'h00F_0F0_F00_FFF);
    wait_done(30);
    check("q5_clr_cnt", clr_cnt, 1);
    check("q5_ind_cnt", ind_cnt, 1);
    check("q5_clr_before_ind", (clr_cyc >= 0) && (clr_cyc < first_ind_cyc), 1);
    check("q5_done_lat", done_cyc - last_ind_cyc, 3);
    check("q5_class", o_class, 0);
    check("q5_votes", o_vote_count, 2);
    check("q5_empty", o_empty, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
